csi2tx_lb_reg_target: RTL and testbench

Local-bus target (responder) for the CSI-2 TX AHB slave bridge. It accepts one-cycle lb_cs strobes carrying address, byte lanes and write data, and decodes them into an 8-word control/status register bank. It returns lb_rdyh, lb_din and ahb_error_flag, inserting programmable wait states and a two-cycle AHB ERROR response for illegal accesses. It sits between the AHB bridge and the CSI-2 TX core configuration and interrupt logic.

---
 rtl/csi2tx_lb_reg_target_if.sv | 25 ++
 rtl/csi2tx_lb_reg_target.sv | 176 +++++++++++++++++
 tb/tb_csi2tx_lb_reg_target.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csi2tx_lb_reg_target_if.sv
// Local-bus link between the CSI-2 TX AHB slave bridge (master) and its register target (slave).
interface csi2tx_lb_reg_target_if #(
    parameter int ADDSIZ = 32,
    parameter int DATSIZ = 32
);
    logic              lb_cs;
    logic              lb_adsm;
    logic              lb_wrout;
    logic [3:0]        lb_beout;
    logic [ADDSIZ-1:0] lb_aout;
    logic [DATSIZ-1:0] lb_dout;
    logic              lb_rdyh;
    logic [DATSIZ-1:0] lb_din;
    logic              ahb_error_flag;

    modport master (
        output lb_cs, lb_adsm, lb_wrout, lb_beout, lb_aout, lb_dout,
        input  lb_rdyh, lb_din, ahb_error_flag
    );

    modport slave (
        input  lb_cs, lb_adsm, lb_wrout, lb_beout, lb_aout, lb_dout,
        output lb_rdyh, lb_din, ahb_error_flag
    );
endinterface

// File: rtl/csi2tx_lb_reg_target.sv
// Local-bus register target: 8-word CSR bank with programmable wait states and
// a two-cycle ERROR response for out-of-window, out-of-range or zero-lane accesses.
//
// state | meaning
// IDLE  | ready; captures a strobe and decodes it
// WAIT  | wait-state countdown
// DONE  | one-cycle completion: commit write / drive read data
// ERR1  | first ERROR cycle, bus held not ready
// ERR2  | second ERROR cycle, ready released
module csi2tx_lb_reg_target #(
    parameter int                ADDSIZ      = 32,
    parameter int                DATSIZ      = 32,
    parameter logic [ADDSIZ-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 1,
    parameter logic [31:0]       ID_VALUE    = 32'h0C51_0103
) (
    input  logic                         clk_ahb,
    input  logic                         rstahb_n,
    csi2tx_lb_reg_target_if.slave        lb,
    input  logic [31:0]                  sts_set_i,
    output logic [31:0]                  ctrl_o,
    output logic [31:0]                  cfg0_o,
    output logic [31:0]                  cfg1_o,
    output logic                         irq_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DONE = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q;
    logic        wr_q;
    logic [3:0]  be_q;
    logic [2:0]  idx_q;
    logic [31:0] wdata_q;

    logic [31:0] ctrl_q, status_q, int_en_q, scratch_q, cfg0_q, cfg1_q, xfer_cnt_q;
    logic [31:0] be_mask;
    logic [31:0] w1c_clr;
    logic [31:0] rd_data;
    logic        dec_err;
    logic        commit;
    logic        unused_ok;

    assign unused_ok = lb.lb_adsm;

    assign dec_err = (lb.lb_aout[ADDSIZ-1:12] != BASE_ADDR[ADDSIZ-1:12])
                   || (|lb.lb_aout[11:5])
                   || (lb.lb_beout == 4'b0000);

    always_ff @(posedge clk_ahb or negedge rstahb_n) begin
        if (!rstahb_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (lb.lb_cs) begin
                    if (dec_err)              state_d = S_ERR1;
                    else if (WAIT_STATES > 0) state_d = S_WAIT;
                    else                      state_d = S_DONE;
                end
            end
            S_WAIT:  if (wait_cnt_q == 4'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lb.lb_rdyh        = 1'b0;
        lb.ahb_error_flag = 1'b0;
        lb.lb_din         = '0;
        case (state_q)
            S_IDLE: lb.lb_rdyh = !lb.lb_cs;
            S_DONE: begin
                lb.lb_rdyh = 1'b1;
                if (!wr_q) lb.lb_din = rd_data;
            end
            S_ERR1: lb.ahb_error_flag = 1'b1;
            S_ERR2: begin
                lb.lb_rdyh        = 1'b1;
                lb.ahb_error_flag = 1'b1;
            end
            default: ;
        endcase
    end

    // Access capture and wait-state down-counter.
    always_ff @(posedge clk_ahb or negedge rstahb_n) begin
        if (!rstahb_n) begin
            wait_cnt_q <= 4'd0;
            wr_q       <= 1'b0;
            be_q       <= 4'd0;
            idx_q      <= 3'd0;
            wdata_q    <= 32'd0;
        end else if (state_q == S_IDLE && lb.lb_cs) begin
            wait_cnt_q <= WAIT_LOAD;
            wr_q       <= lb.lb_wrout;
            be_q       <= lb.lb_beout;
            idx_q      <= lb.lb_aout[4:2];
            wdata_q    <= lb.lb_dout[31:0];
        end else if (state_q == S_WAIT && wait_cnt_q != 4'd0) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
        end
    end

    assign be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    assign commit  = (state_q == S_DONE) && wr_q;
    assign w1c_clr = (commit && idx_q == 3'd2) ? (wdata_q & be_mask) : 32'd0;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // STATUS set is OR'd after the W1C clear so a same-cycle set survives.
    always_ff @(posedge clk_ahb or negedge rstahb_n) begin
        if (!rstahb_n) begin
            ctrl_q     <= 32'd0;
            status_q   <= 32'd0;
            int_en_q   <= 32'd0;
            scratch_q  <= 32'd0;
            cfg0_q     <= 32'd0;
            cfg1_q     <= 32'd0;
            xfer_cnt_q <= 32'd0;
            irq_o      <= 1'b0;
        end else begin
            if (commit) begin
                case (idx_q)
                    3'd1:    ctrl_q    <= merge(ctrl_q,    wdata_q, be_mask);
                    3'd3:    int_en_q  <= merge(int_en_q,  wdata_q, be_mask);
                    3'd4:    scratch_q <= merge(scratch_q, wdata_q, be_mask);
                    3'd5:    cfg0_q    <= merge(cfg0_q,    wdata_q, be_mask);
                    3'd6:    cfg1_q    <= merge(cfg1_q,    wdata_q, be_mask);
                    default: ;
                endcase
            end
            status_q <= (status_q & ~w1c_clr) | sts_set_i;
            if (state_q == S_DONE) xfer_cnt_q <= xfer_cnt_q + 32'd1;
            irq_o <= |(status_q & int_en_q);
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (idx_q)
            3'd0: rd_data = ID_VALUE;
            3'd1: rd_data = ctrl_q;
            3'd2: rd_data = status_q;
            3'd3: rd_data = int_en_q;
            3'd4: rd_data = scratch_q;
            3'd5: rd_data = cfg0_q;
            3'd6: rd_data = cfg1_q;
            3'd7: rd_data = xfer_cnt_q;
            default: rd_data = 32'd0;
        endcase
    end

    assign ctrl_o = ctrl_q;
    assign cfg0_o = cfg0_q;
    assign cfg1_o = cfg1_q;

endmodule

// File: tb/tb_csi2tx_lb_reg_target.sv
// Bench for csi2tx_lb_reg_target: three instances (1, 0 and 15 wait states) on a shared
// stimulus bus, checked against a register-map model kept here.
module tb_csi2tx_lb_reg_target;

    localparam logic [31:0] ID   = 32'h0C51_0103;
    localparam int          WS_M = 1;

    logic clk_ahb  = 1'b0;
    logic rstahb_n = 1'b0;
    always #5 clk_ahb = ~clk_ahb;

    logic        cs = 1'b0, adsm = 1'b0, wr = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0, sts = 32'd0;
    int          sel = 0;

    int checks = 0;
    int errors = 0;

    csi2tx_lb_reg_target_if bus_m ();
    csi2tx_lb_reg_target_if bus_z ();
    csi2tx_lb_reg_target_if bus_l ();

    assign bus_m.lb_cs = cs && (sel == 0);
    assign bus_z.lb_cs = cs && (sel == 1);
    assign bus_l.lb_cs = cs && (sel == 2);
    assign bus_m.lb_adsm = adsm && (sel == 0);
    assign bus_z.lb_adsm = adsm && (sel == 1);
    assign bus_l.lb_adsm = adsm && (sel == 2);
    assign bus_m.lb_wrout = wr;  assign bus_z.lb_wrout = wr;  assign bus_l.lb_wrout = wr;
    assign bus_m.lb_beout = be;  assign bus_z.lb_beout = be;  assign bus_l.lb_beout = be;
    assign bus_m.lb_aout = addr; assign bus_z.lb_aout = addr; assign bus_l.lb_aout = addr;
    assign bus_m.lb_dout = wdata; assign bus_z.lb_dout = wdata; assign bus_l.lb_dout = wdata;

    logic [31:0] ctrl_m, cfg0_m, cfg1_m;
    logic        irq_m;
    logic [31:0] unused_ctrl_z, unused_cfg0_z, unused_cfg1_z;
    logic [31:0] unused_ctrl_l, unused_cfg0_l, unused_cfg1_l;
    logic        unused_irq_z, unused_irq_l;

    csi2tx_lb_reg_target #(.WAIT_STATES(WS_M)) dut (
        .clk_ahb(clk_ahb), .rstahb_n(rstahb_n), .lb(bus_m), .sts_set_i(sts),
        .ctrl_o(ctrl_m), .cfg0_o(cfg0_m), .cfg1_o(cfg1_m), .irq_o(irq_m));

    csi2tx_lb_reg_target #(.WAIT_STATES(0)) dut_z (
        .clk_ahb(clk_ahb), .rstahb_n(rstahb_n), .lb(bus_z), .sts_set_i(sts),
        .ctrl_o(unused_ctrl_z), .cfg0_o(unused_cfg0_z), .cfg1_o(unused_cfg1_z), .irq_o(unused_irq_z));

    csi2tx_lb_reg_target #(.WAIT_STATES(15)) dut_l (
        .clk_ahb(clk_ahb), .rstahb_n(rstahb_n), .lb(bus_l), .sts_set_i(sts),
        .ctrl_o(unused_ctrl_l), .cfg0_o(unused_cfg0_l), .cfg1_o(unused_cfg1_l), .irq_o(unused_irq_l));

    logic        rdy_o, err_o;
    logic [31:0] din_o;
    always_comb begin
        rdy_o = bus_m.lb_rdyh; err_o = bus_m.ahb_error_flag; din_o = bus_m.lb_din;
        if (sel == 1) begin
            rdy_o = bus_z.lb_rdyh; err_o = bus_z.ahb_error_flag; din_o = bus_z.lb_din;
        end else if (sel == 2) begin
            rdy_o = bus_l.lb_rdyh; err_o = bus_l.ahb_error_flag; din_o = bus_l.lb_din;
        end
    end

    // Register-map model of the 1-wait-state instance.
    logic [31:0] m_reg [8];
    logic [31:0] m_xfer;

    function automatic logic [31:0] lane_mask(input logic [3:0] b);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{b[i]}};
        return m;
    endfunction

    function automatic logic [31:0] model_rd(input int off);
        if (off == 0) return ID;
        if (off == 7) return m_xfer;
        return m_reg[off];
    endfunction

    task automatic model_wr(input int off, input logic [3:0] b, input logic [31:0] d);
        logic [31:0] m;
        m = lane_mask(b);
        if (off == 2)                 m_reg[2] = m_reg[2] & ~(d & m);
        else if (off != 0 && off != 7) m_reg[off] = (m_reg[off] & ~m) | (d & m);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the target idle; returns at the negedge after completion.
    task automatic xfer(input int s, input bit w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd, output logic e_low,
                        output logic e_done, output int lowc);
        bit done;
        done = 1'b0;
        sel = s; cs = 1'b1; adsm = !w; wr = w; addr = a; be = b; wdata = d;
        lowc = 0; e_low = 1'b0; e_done = 1'b0; rd = 32'd0;
        #1;
        if (!rdy_o) lowc++;
        @(negedge clk_ahb);
        cs = 1'b0; adsm = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (rdy_o) begin
                done = 1'b1; rd = din_o; e_done = err_o;
            end else begin
                lowc++; e_low = err_o;
                @(negedge clk_ahb);
            end
        end
        check("completion_within_budget", {31'd0, done}, 32'd1);
        @(posedge clk_ahb);
        #1 sts = 32'd0;
        @(negedge clk_ahb);
    endtask

    task automatic do_op(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        logic [31:0] rd, exp_rd;
        logic        el, ed;
        int          lowc, off;
        bit          bad;
        bad    = (a[31:12] != 20'h0) || (a[11:0] >= 12'h020) || (b == 4'h0);
        off    = int'(a[4:2]);
        exp_rd = (bad || w) ? 32'd0 : model_rd(off);
        xfer(0, w, a, b, d, rd, el, ed, lowc);
        check("rdy_low_cycles", lowc, bad ? 2 : 1 + WS_M);
        check("err_in_err1", {31'd0, el}, {31'd0, bad});
        check("err_at_done", {31'd0, ed}, {31'd0, bad});
        if (!w) check("rdata", rd, exp_rd);
        if (!bad) begin
            if (w) model_wr(off, b, d);
            m_xfer = m_xfer + 32'd1;
        end
        check("ctrl_o", ctrl_m, m_reg[1]);
        check("cfg0_o", cfg0_m, m_reg[5]);
        check("cfg1_o", cfg1_m, m_reg[6]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a;
        logic        el, ed;
        int          lowc, r;

        for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
        m_xfer = 32'd0;

        repeat (3) @(negedge clk_ahb);
        check("reset_rdy", {31'd0, rdy_o}, 32'd1);
        check("reset_err", {31'd0, err_o}, 32'd0);
        check("reset_din", din_o, 32'd0);
        check("reset_ctrl", ctrl_m, 32'd0);
        check("reset_irq", {31'd0, irq_m}, 32'd0);
        rstahb_n = 1'b1;
        @(negedge clk_ahb);

        do_op(1'b0, 32'h00, 4'hF, 32'd0);
        do_op(1'b0, 32'h1C, 4'hF, 32'd0);

        do_op(1'b1, 32'h04, 4'hF, 32'h1122_3344);
        do_op(1'b1, 32'h04, 4'b0101, 32'hAABB_CCDD);
        check("ctrl_lane_merge", ctrl_m, 32'h11BB_33DD);
        do_op(1'b0, 32'h04, 4'b0001, 32'd0);
        do_op(1'b1, 32'h00, 4'hF, 32'hFFFF_FFFF);
        do_op(1'b1, 32'h1C, 4'hF, 32'hFFFF_FFFF);
        do_op(1'b0, 32'h1C, 4'hF, 32'd0);

        do_op(1'b1, 32'h0C, 4'hF, 32'h8);
        sts = 32'h8;
        @(negedge clk_ahb);
        sts = 32'd0;
        m_reg[2] = 32'h8;
        check("irq_registered_delay", {31'd0, irq_m}, 32'd0);
        @(negedge clk_ahb);
        check("irq_set", {31'd0, irq_m}, 32'd1);
        do_op(1'b0, 32'h08, 4'hF, 32'd0);
        do_op(1'b1, 32'h08, 4'hF, 32'h8);
        @(negedge clk_ahb);
        check("irq_cleared", {31'd0, irq_m}, 32'd0);
        do_op(1'b0, 32'h08, 4'hF, 32'd0);
        sts = 32'h8;
        do_op(1'b1, 32'h08, 4'hF, 32'h8);
        m_reg[2] = m_reg[2] | 32'h8;
        do_op(1'b0, 32'h08, 4'hF, 32'd0);
        do_op(1'b1, 32'h08, 4'hF, 32'h8);

        do_op(1'b0, 32'h20, 4'hF, 32'd0);
        do_op(1'b0, 32'h1004, 4'hF, 32'd0);
        do_op(1'b1, 32'h04, 4'h0, 32'hFFFF_FFFF);
        do_op(1'b0, 32'h1C, 4'hF, 32'd0);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = 32'(r * 4);
            else if (r == 8) a = 32'h20 + 32'($urandom_range(0, 8) * 4);
            else             a = 32'h1000 + 32'($urandom_range(0, 7) * 4);
            do_op(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
        end
        @(negedge clk_ahb);
        check("irq_random_phase", {31'd0, irq_m}, {31'd0, |(m_reg[2] & m_reg[3])});

        xfer(1, 1'b1, 32'h10, 4'hF, 32'h5A5A_5A5A, rd, el, ed, lowc);
        check("ws0_write_lat", lowc, 1);
        xfer(1, 1'b0, 32'h10, 4'hF, 32'd0, rd, el, ed, lowc);
        check("ws0_read_lat", lowc, 1);
        check("ws0_read_data", rd, 32'h5A5A_5A5A);
        xfer(2, 1'b0, 32'h00, 4'hF, 32'd0, rd, el, ed, lowc);
        check("ws15_read_lat", lowc, 16);
        check("ws15_read_data", rd, ID);
        sel = 0;

        cs = 1'b1; wr = 1'b1; addr = 32'h14; be = 4'hF; wdata = 32'h1234_5678;
        @(negedge clk_ahb);
        cs = 1'b0;
        check("midreset_in_wait", {31'd0, rdy_o}, 32'd0);
        rstahb_n = 1'b0;
        #1;
        check("midreset_idle", {31'd0, rdy_o}, 32'd1);
        @(negedge clk_ahb);
        rstahb_n = 1'b1;
        repeat (2) @(negedge clk_ahb);
        check("midreset_cfg0", cfg0_m, 32'd0);
        check("midreset_rdy", {31'd0, rdy_o}, 32'd1);
        check("midreset_err", {31'd0, err_o}, 32'd0);
        for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
        m_xfer = 32'd0;
        do_op(1'b0, 32'h1C, 4'hF, 32'd0);
        do_op(1'b0, 32'h14, 4'hF, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
